// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver with a 16x oversampling front end.
// Each byte goes to the host on a valid/ack handshake, with framing and overrun status.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit and a parity_err output.
module uart_rx #(
  parameter int unsigned CLOCK = 50000000,
  parameter int unsigned RATE  = 9600
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] rch,
  output logic       valid,
  input  logic       ack,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int unsigned DIV = CLOCK / (RATE * 16);
  localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHi
  } state_e;

  state_e        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    tcnt_q, tcnt_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    rch_q, rch_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          ovr_q, ovr_d;
  logic          tick;
  logic          done;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
  logic          pe_q, pe_d;
`endif

  assign tick = (presc_q == PW'(DIV - 1));

  // Two-flop synchronizer for the asynchronous line; resets to the idle level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receiver state, counters, shift register and host-facing registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      presc_q  <= '0;
      tcnt_q   <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      rch_q    <= '0;
      valid_q  <= 1'b0;
      fe_q     <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q    <= 1'b0;
      pe_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      tcnt_q   <= tcnt_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      rch_q    <= rch_d;
      valid_q  <= valid_d;
      fe_q     <= fe_d;
      ovr_q    <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q    <= par_d;
      pe_q     <= pe_d;
`endif
    end
  end

  // Frame FSM: next state, prescaler, tick counter and data shifting.
  always_comb begin
    state_d  = state_q;
    presc_d  = tick ? '0 : presc_q + PW'(1);
    tcnt_d   = tick ? tcnt_q + 4'd1 : tcnt_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    done     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        tcnt_d = '0;
        if (!rx_s_q) begin
          // Align the bit grid to the observed falling edge.
          state_d = StStart;
          presc_d = '0;
        end
      end
      StStart: begin
        if (tick && tcnt_q == 4'd7) begin
          tcnt_d = '0;
          if (!rx_s_q) begin
            state_d  = StData;
            bitcnt_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (tick && tcnt_q == 4'd15) begin
          shreg_d  = {rx_s_q, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
      StParity: begin
`ifdef UART_RX_PARITY_EN
        if (tick && tcnt_q == 4'd15) begin
          par_d   = rx_s_q;
          state_d = StStop;
        end
`else
        state_d = StIdle;
`endif
      end
      StStop: begin
        if (tick && tcnt_q == 4'd15) begin
          done = 1'b1;
          // A low stop bit may be a break; wait for the line to return high.
          state_d = rx_s_q ? StIdle : StWaitHi;
        end
      end
      StWaitHi: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Host handshake: load completed bytes, clear on ack, flag dropped bytes.
  always_comb begin
    rch_d   = rch_q;
    valid_d = valid_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;
`ifdef UART_RX_PARITY_EN
    pe_d    = pe_q;
`endif
    if (valid_q && ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (done) begin
      if (valid_q && !ack) begin
        ovr_d = 1'b1;
      end else begin
        rch_d   = shreg_q;
        fe_d    = ~rx_s_q;
        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        pe_d    = ^{shreg_q, par_q};
`endif
      end
    end
  end

  assign rch       = rch_q;
  assign valid     = valid_q;
  assign frame_err = fe_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_err = pe_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 160 clk per bit (DIV=10).
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int LAT    = 1683;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int LAT    = 1523;
`endif
  localparam int BIT = 160;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] rch;
  logic       valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned rise_cyc = 0;
  logic valid_prev = 1'b0;

  uart_rx #(.CLOCK(1600000), .RATE(10000)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rxd       (rxd),
    .rch       (rch),
    .valid     (valid),
    .ack       (ack),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle at which valid rises, sampled on the falling edge.
  always @(negedge clk) begin
    if (valid && !valid_prev) rise_cyc = cyc;
    valid_prev = valid;
  end

  task automatic send_bit(input logic b, input int n);
    rxd = b;
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; parity bit is even parity of d, inverted when flip=1.
  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop,
                            input int stop_clks);
    start_cyc = cyc;
    send_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) send_bit(d[i], BIT);
    if (PAR_EN) send_bit((^d) ^ flip, BIT);
    send_bit(stop, stop_clks);
    rxd = 1'b1;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rch !== 8'h00) begin failures++; $display("FAIL rst_rch got=%h exp=00", rch); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rst_fe got=%b exp=0", frame_err); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_ovr got=%b exp=0", overrun); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_frame_55();
    int unsigned lat;
    send_frame(8'h55, 1'b0, 1'b1, BIT);
    repeat (20) @(negedge clk);
    lat = rise_cyc - start_cyc;
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL f55_valid got=%b exp=1", valid); end
    checks++; if (lat < LAT - 3 || lat > LAT + 3)
      begin failures++; $display("FAIL f55_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (rch !== 8'h55) begin failures++; $display("FAIL f55_rch got=%h exp=55", rch); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL f55_fe got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL f55_busy got=%b exp=0", busy); end
    ack_pulse();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL f55_ack got=%b exp=0", valid); end
  endtask

  task automatic test_glitch();
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL gl_busy_hi got=%b exp=1", busy); end
    repeat (28) @(negedge clk);
    rxd = 1'b1;
    repeat (42) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL gl_busy_lo got=%b exp=0", busy); end
    repeat (1600) @(negedge clk);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL gl_valid got=%b exp=0", valid); end
  endtask

  task automatic test_break();
    send_frame(8'hA5, 1'b0, 1'b0, 400);
    repeat (BIT) @(negedge clk);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL brk_valid got=%b exp=1", valid); end
    checks++; if (rch !== 8'hA5) begin failures++; $display("FAIL brk_rch got=%h exp=a5", rch); end
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL brk_fe got=%b exp=1", frame_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL brk_busy got=%b exp=0", busy); end
    ack_pulse();
    repeat (400) @(negedge clk);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL brk_second got=%b exp=0", valid); end
    send_frame(8'h3C, 1'b0, 1'b1, BIT);
    repeat (20) @(negedge clk);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL f3c_valid got=%b exp=1", valid); end
    checks++; if (rch !== 8'h3C) begin failures++; $display("FAIL f3c_rch got=%h exp=3c", rch); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL f3c_fe got=%b exp=0", frame_err); end
    ack_pulse();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h12, 1'b0, 1'b1, BIT);
    send_frame(8'h34, 1'b0, 1'b1, BIT);
    repeat (20) @(negedge clk);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", valid); end
    checks++; if (rch !== 8'h12) begin failures++; $display("FAIL b2b_rch got=%h exp=12", rch); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL b2b_ovr got=%b exp=1", overrun); end
    ack_pulse();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL b2b_ack_valid got=%b exp=0", valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_ack_ovr got=%b exp=0", overrun); end
  endtask

  task automatic test_same_clk_ack();
    send_frame(8'h56, 1'b0, 1'b1, BIT);
    fork
      send_frame(8'h78, 1'b0, 1'b1, BIT);
      begin
        repeat (LAT - 1) @(negedge clk);
        ack_pulse();
      end
    join
    repeat (20) @(negedge clk);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL same_valid got=%b exp=1", valid); end
    checks++; if (rch !== 8'h78) begin failures++; $display("FAIL same_rch got=%h exp=78", rch); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL same_ovr got=%b exp=0", overrun); end
  endtask

  // Leaves rch=0x78 unacknowledged from the previous test so reset has visible work to do.
  task automatic test_midframe_reset();
    fork
      send_frame(8'hF0, 1'b0, 1'b1, BIT);
      begin
        repeat (BIT * 5 + 80) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mr_pre_busy got=%b exp=1", busy); end
        reset_n = 1'b0;
        #1;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mr_valid got=%b exp=0", valid); end
        checks++; if (rch !== 8'h00) begin failures++; $display("FAIL mr_rch got=%h exp=00", rch); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mr_busy got=%b exp=0", busy); end
        checks++; if (overrun !== 1'b0 || frame_err !== 1'b0)
          begin failures++; $display("FAIL mr_status got=%b%b exp=00", overrun, frame_err); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
      end
    join
    repeat (2 * BIT) @(negedge clk);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mr_partial got=%b exp=0", valid); end
    send_frame(8'hC3, 1'b0, 1'b1, BIT);
    repeat (20) @(negedge clk);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL c3_valid got=%b exp=1", valid); end
    checks++; if (rch !== 8'hC3) begin failures++; $display("FAIL c3_rch got=%h exp=c3", rch); end
    ack_pulse();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h07, 1'b0, 1'b1, BIT);
    repeat (20) @(negedge clk);
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL par_ok got=%b exp=0", parity_err); end
    ack_pulse();
    send_frame(8'h07, 1'b1, 1'b1, BIT);
    repeat (20) @(negedge clk);
    checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL par_bad got=%b exp=1", parity_err); end
    checks++; if (rch !== 8'h07) begin failures++; $display("FAIL par_rch got=%h exp=07", rch); end
    ack_pulse();
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_frame_55();
    test_glitch();
    test_break();
    test_back_to_back();
    test_same_clk_ack();
    test_midframe_reset();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
